// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch control FSM and its surroundings:
// the four buttons and the BCD counter on one side, counter strobes and display value on the other.
interface stopwatch_ctrl_if;
  logic        btn_start;
  logic        btn_stop;
  logic        btn_lap;
  logic        btn_clear;
  logic [15:0] cnt_bcd;
  logic        cnt_inc;
  logic        cnt_clr;
  logic [15:0] disp_bcd;
  logic        running;
  logic        frozen;
  logic [1:0]  state;

  modport master (
    output btn_start, btn_stop, btn_lap, btn_clear, cnt_bcd,
    input  cnt_inc, cnt_clr, disp_bcd, running, frozen, state
  );

  modport slave (
    input  btn_start, btn_stop, btn_lap, btn_clear, cnt_bcd,
    output cnt_inc, cnt_clr, disp_bcd, running, frozen, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: synchronises the buttons, sequences the BCD counter
// (0.1 s increment strobe, clear strobe) and freezes the displayed value for laps.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned PRESC_W  = 23,
  parameter logic [15:0] MAX_BCD  = 16'h9599
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  bus
);

  // state | meaning
  // IDLE  | cleared or never started, counter held
  // RUN   | counting, display live
  // STOP  | paused, prescaler phase kept for resume
  // LAP   | counting, display frozen at lap_q
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_t;

  // Button vectors ordered {clear, stop, start, lap}
  logic [3:0] btn_s1_q, btn_s2_q, btn_s3_q;
  logic [3:0] ev;
  logic       ev_clear, ev_stop, ev_start, ev_lap;

  state_t              state_q;
  logic [PRESC_W-1:0]  presc_q;
  logic [15:0]         lap_q;
  logic                cnt_inc_q;
  logic                cnt_clr_q;

  logic                live;
  logic                tick_due;
  logic                at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      btn_s3_q <= '0;
    end else begin
      btn_s1_q <= {bus.btn_clear, bus.btn_stop, bus.btn_start, bus.btn_lap};
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;
    end
  end

  assign ev = btn_s2_q & ~btn_s3_q;

  // Only the highest-priority event of a cycle survives
  assign ev_clear = ev[3];
  assign ev_stop  = ev[2] & ~ev[3];
  assign ev_start = ev[1] & ~(|ev[3:2]);
  assign ev_lap   = ev[0] & ~(|ev[3:1]);

  assign live     = (state_q == RUN) || (state_q == LAP);
  assign tick_due = live && (presc_q == PRESC_W'(TICK_DIV - 1));
  assign at_max   = (bus.cnt_bcd == MAX_BCD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      lap_q     <= '0;
      cnt_inc_q <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      cnt_inc_q <= 1'b0;
      cnt_clr_q <= 1'b0;

      // A stop freezes the prescaler phase unless the tick is already due
      if (live) begin
        if (tick_due) begin
          presc_q <= '0;
          if (!at_max) cnt_inc_q <= 1'b1;
        end else if (!ev_stop) begin
          presc_q <= presc_q + PRESC_W'(1);
        end
      end

      unique case (state_q)
        IDLE: begin
          if (ev_clear) begin
            cnt_clr_q <= 1'b1;
          end else if (ev_start) begin
            state_q <= RUN;
            presc_q <= '0;
          end
        end
        RUN: begin
          if (ev_stop) begin
            state_q <= STOP;
          end else if (ev_lap) begin
            state_q <= LAP;
            lap_q   <= bus.cnt_bcd;
          end
        end
        LAP: begin
          if (ev_stop)     state_q <= STOP;
          else if (ev_lap) state_q <= RUN;
        end
        STOP: begin
          if (ev_clear) begin
            state_q   <= IDLE;
            cnt_clr_q <= 1'b1;
            presc_q   <= '0;
          end else if (ev_start && !at_max) begin
            state_q <= RUN;
          end
        end
      endcase

      if (tick_due && at_max) state_q <= STOP;
    end
  end

  assign bus.cnt_inc  = cnt_inc_q;
  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.state    = state_q;
  assign bus.running  = live;
  assign bus.frozen   = (state_q == LAP);
  assign bus.disp_bcd = (state_q == LAP) ? lap_q : bus.cnt_bcd;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4; expected values are hand-derived
// from the button-to-state latency (3 edges) and the 4-cycle tick period.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .PRESC_W  (3),
    .MAX_BCD  (16'h9599)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] m);
    {bus.btn_clear, bus.btn_stop, bus.btn_start, bus.btn_lap} = m;
  endtask

  task automatic run(input int n, output int incs, output int clrs);
    incs = 0;
    clrs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      incs += int'(bus.cnt_inc);
      clrs += int'(bus.cnt_clr);
    end
  endtask

  // mask order {clear, stop, start, lap}; the event acts on the 3rd edge
  task automatic press(input logic [3:0] m, output int incs, output int clrs);
    set_btn(m);
    run(3, incs, clrs);
    set_btn(4'b0000);
  endtask

  task automatic wait_inc(output int k);
    k = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus.cnt_inc === 1'b1 && k == 0) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int incs, clrs, incs2, clrs2, k, bad;

    rst_n = 1'b0;
    set_btn(4'b0000);
    bus.cnt_bcd = 16'h0042;
    repeat (3) tick();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_inc", 32'(bus.cnt_inc), 32'd0);
    chk("rst_clr", 32'(bus.cnt_clr), 32'd0);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_frozen", 32'(bus.frozen), 32'd0);
    chk("rst_disp", 32'(bus.disp_bcd), 32'h0042);
    rst_n = 1'b1;
    tick();

    // 1: start, tick period
    press(4'b0010, incs, clrs);
    chk("t1_state_run", 32'(bus.state), 32'd1);
    chk("t1_running", 32'(bus.running), 32'd1);
    wait_inc(k);
    chk("t1_first_inc", 32'(k), 32'd4);
    tick();
    chk("t1_inc_width", 32'(bus.cnt_inc), 32'd0);
    wait_inc(k);
    chk("t1_second_inc", 32'(k), 32'd3);

    // 2: stop with prescaler at 2, resume
    press(4'b0100, incs, clrs);
    chk("t2_state_stop", 32'(bus.state), 32'd2);
    chk("t2_press_inc", 32'(incs), 32'd0);
    run(20, incs, clrs);
    chk("t2_stopped_inc", 32'(incs), 32'd0);
    chk("t2_running", 32'(bus.running), 32'd0);
    press(4'b0010, incs, clrs);
    chk("t2_state_resume", 32'(bus.state), 32'd1);
    wait_inc(k);
    chk("t2_resume_inc", 32'(k), 32'd2);

    // 3: lap freeze (button held to confirm a single event), lap release, clear ignored
    bus.cnt_bcd = 16'h0123;
    set_btn(4'b0001);
    repeat (10) tick();
    set_btn(4'b0000);
    chk("t3_state_lap", 32'(bus.state), 32'd3);
    chk("t3_frozen", 32'(bus.frozen), 32'd1);
    chk("t3_running", 32'(bus.running), 32'd1);
    bus.cnt_bcd = 16'h0124;
    tick();
    chk("t3_disp_frozen", 32'(bus.disp_bcd), 32'h0123);
    press(4'b0001, incs, clrs);
    chk("t3_state_run", 32'(bus.state), 32'd1);
    chk("t3_unfrozen", 32'(bus.frozen), 32'd0);
    chk("t3_disp_live", 32'(bus.disp_bcd), 32'h0124);
    press(4'b1000, incs, clrs);
    chk("t3_clear_ignored", 32'(bus.state), 32'd1);

    // 4: stop beats start; clear beats start in STOP
    press(4'b0110, incs, clrs);
    chk("t4_stop_prio", 32'(bus.state), 32'd2);
    press(4'b1010, incs, clrs);
    run(5, incs2, clrs2);
    chk("t4_state_idle", 32'(bus.state), 32'd0);
    chk("t4_clr_count", 32'(clrs + clrs2), 32'd1);
    chk("t4_inc_count", 32'(incs + incs2), 32'd0);

    // 5: saturation
    bus.cnt_bcd = 16'h9599;
    press(4'b0010, incs, clrs);
    chk("t5_state_run", 32'(bus.state), 32'd1);
    run(8, incs, clrs);
    chk("t5_sat_inc", 32'(incs), 32'd0);
    chk("t5_sat_stop", 32'(bus.state), 32'd2);
    press(4'b0010, incs, clrs);
    chk("t5_start_ignored", 32'(bus.state), 32'd2);
    press(4'b1000, incs, clrs);
    chk("t5_clear_idle", 32'(bus.state), 32'd0);
    chk("t5_clear_pulse", 32'(clrs), 32'd1);

    // 6: asynchronous reset mid-RUN, then idle soak
    bus.cnt_bcd = 16'h0000;
    press(4'b0010, incs, clrs);
    chk("t6_state_run", 32'(bus.state), 32'd1);
    tick();
    tick();
    bus.cnt_bcd = 16'h0777;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_state", 32'(bus.state), 32'd0);
    chk("t6_async_running", 32'(bus.running), 32'd0);
    chk("t6_async_inc", 32'(bus.cnt_inc), 32'd0);
    chk("t6_async_disp", 32'(bus.disp_bcd), 32'h0777);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    incs = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.state !== 2'b00) bad++;
      incs += int'(bus.cnt_inc);
    end
    chk("t6_idle_soak", 32'(bad), 32'd0);
    chk("t6_idle_inc", 32'(incs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
